// File: rtl/pulse_event_arbiter.sv
// Per-channel edge/pulse detectors feeding sticky pending bits, shared through one
// round-robin valid/ready event port with per-channel overflow flags.
module pulse_event_arbiter #(
  parameter int   N           = 4,
  parameter int   DETECT_MODE = 0,
  localparam int  IDW         = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IDW-1:0] out_id,
  output logic [N-1:0]   overflow,
  input  logic           clear_overflow
);

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t         state_r, state_next_s;
  logic [N-1:0]   h1_r, h2_r, pending_r, overflow_r;
  logic [IDW-1:0] rr_ptr_r, out_id_r, rr_next_s, pick_s;
  logic [N-1:0]   det_s, acc_s, cand_s;
  logic           transfer_s, load_s, found_s;

  assign out_id   = out_id_r;
  assign overflow = overflow_r;

  // Detector: mode 1 fires on the cycle the line falls back after exactly one high cycle
  always_comb begin
    if (DETECT_MODE == 0) begin
      det_s = ~h1_r & a;
    end else begin
      det_s = ~h2_r & h1_r & ~a;
    end
  end

  // Transfer bookkeeping and the pointer the next search starts from
  always_comb begin
    transfer_s = out_valid & out_ready;
    acc_s      = transfer_s ? ({{(N-1){1'b0}}, 1'b1} << out_id_r) : {N{1'b0}};
    cand_s     = pending_r & ~acc_s;
    load_s     = (state_r == IDLE) | transfer_s;
    if (transfer_s) begin
      rr_next_s = (out_id_r == IDW'(N - 1)) ? {IDW{1'b0}} : out_id_r + {{(IDW-1){1'b0}}, 1'b1};
    end else begin
      rr_next_s = rr_ptr_r;
    end
  end

  // Round-robin search upward from the post-transfer pointer, wrapping at N-1
  always_comb begin : pick_blk
    int idx;
    idx     = 0;
    found_s = 1'b0;
    pick_s  = {IDW{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_next_s) + k) % N;
      if (!found_s && cand_s[idx]) begin
        found_s = 1'b1;
        pick_s  = IDW'(idx);
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Scheduler state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Scheduler next state: an unaccepted offer is held without re-arbitration
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = found_s ? OFFER : IDLE;
      OFFER: begin
        if (transfer_s) begin
          state_next_s = found_s ? OFFER : IDLE;
        end else begin
          state_next_s = OFFER;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Scheduler outputs
  always_comb begin
    case (state_r)
      OFFER:   out_valid = 1'b1;
      IDLE:    out_valid = 1'b0;
      default: out_valid = 1'b0;
    endcase
  end

  // Detector history, pending/overflow tracking, pointer and offered id
  always_ff @(posedge clk) begin
    if (rst) begin
      h1_r       <= (DETECT_MODE == 0) ? {N{1'b0}} : {N{1'b1}};
      h2_r       <= {N{1'b1}};
      pending_r  <= {N{1'b0}};
      overflow_r <= {N{1'b0}};
      rr_ptr_r   <= {IDW{1'b0}};
      out_id_r   <= {IDW{1'b0}};
    end else begin
      h1_r       <= a;
      h2_r       <= h1_r;
      pending_r  <= det_s | (pending_r & ~acc_s);
      overflow_r <= (clear_overflow ? {N{1'b0}} : overflow_r) | (det_s & pending_r & ~acc_s);
      rr_ptr_r   <= rr_next_s;
      if (load_s && found_s) begin
        out_id_r <= pick_s;
      end else begin
        out_id_r <= out_id_r;
      end
    end
  end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Scoreboard bench: one instance per detect mode; expected event ids are queued as
// stimulus is driven and compared as each transfer is observed.
module tb_pulse_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a0, a1;
  logic       ready0, ready1, clr0, clr1;
  logic       valid0, valid1;
  logic [1:0] id0, id1;
  logic [3:0] ovf0, ovf1;

  int n_tests = 0;
  int n_fail  = 0;
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  pulse_event_arbiter #(.N(4), .DETECT_MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .a(a0), .out_valid(valid0), .out_ready(ready0),
    .out_id(id0), .overflow(ovf0), .clear_overflow(clr0)
  );

  pulse_event_arbiter #(.N(4), .DETECT_MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .a(a1), .out_valid(valid1), .out_ready(ready1),
    .out_id(id1), .overflow(ovf1), .clear_overflow(clr1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transfers are decided at the next posedge; sample them half a cycle early
  always @(negedge clk) begin
    if (rst === 1'b0 && valid0 === 1'b1 && ready0 === 1'b1) begin
      if (q0.size() == 0) check("m0_spurious_event", 32'(valid0), 32'd0);
      else                check("m0_event_id", 32'(id0), 32'(q0.pop_front()));
    end
    if (rst === 1'b0 && valid1 === 1'b1 && ready1 === 1'b1) begin
      if (q1.size() == 0) check("m1_spurious_event", 32'(valid1), 32'd0);
      else                check("m1_event_id", 32'(id1), 32'(q1.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; a0 = 4'hF; a1 = 4'h0;
    ready0 = 1'b0; ready1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    tick(2);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_id", 32'(id0), 32'd0);
    check("rst_overflow", 32'(ovf0), 32'd0);

    // Line held high through reset: detect in first cycle, offer two cycles later
    rst = 1'b0;
    tick();
    check("latency_t1_valid", 32'(valid0), 32'd0);
    tick();
    check("latency_t2_valid", 32'(valid0), 32'd1);
    check("latency_t2_id", 32'(id0), 32'd0);
    for (int i = 0; i < 4; i++) q0.push_back(i);
    ready0 = 1'b1;
    tick(4);
    check("all_granted_idle", 32'(valid0), 32'd0);
    check("all_granted_q", 32'(q0.size()), 32'd0);

    // Backpressure: offer held while a higher-priority channel arrives
    ready0 = 1'b0; a0 = 4'b0000;
    tick();
    a0 = 4'b1010;
    tick(2);
    check("bp_offer_valid", 32'(valid0), 32'd1);
    check("bp_offer_id", 32'(id0), 32'd1);
    a0 = 4'b1011;
    tick();
    a0 = 4'b1010;
    tick();
    check("bp_held_id", 32'(id0), 32'd1);
    q0.push_back(1); q0.push_back(3); q0.push_back(0);
    ready0 = 1'b1;
    tick(5);
    check("bp_drained", 32'(q0.size()), 32'd0);

    // Overflow: second detect while pending, clear racing a set, then plain clear
    ready0 = 1'b0; a0 = 4'b0000;
    tick();
    a0 = 4'b0010;
    tick();
    a0 = 4'b0000;
    tick();
    a0 = 4'b0010;
    tick();
    check("ovf_set", 32'(ovf0), 32'h2);
    a0 = 4'b0000;
    tick();
    a0 = 4'b0010; clr0 = 1'b1;
    tick();
    check("ovf_set_beats_clear", 32'(ovf0), 32'h2);
    a0 = 4'b0000;
    tick();
    check("ovf_cleared", 32'(ovf0), 32'h0);
    clr0 = 1'b0;
    check("ovf_offer_id", 32'(id0), 32'd1);
    q0.push_back(1);
    ready0 = 1'b1;
    tick(3);

    // Same-cycle detect and accept on channel 0 re-queues it behind channel 1
    ready0 = 1'b0;
    a0 = 4'b0011;
    tick();
    a0 = 4'b0000;
    tick();
    check("same_offer_id", 32'(id0), 32'd0);
    q0.push_back(0); q0.push_back(1); q0.push_back(0);
    a0 = 4'b0001; ready0 = 1'b1;
    tick();
    a0 = 4'b0000;
    tick(4);
    check("same_overflow", 32'(ovf0), 32'h0);
    check("same_drained", 32'(q0.size()), 32'd0);

    // Reset in the middle of an offer drops it; mode 1 sees no pulse from 1,0 after reset
    ready0 = 1'b0;
    a0 = 4'b0100;
    tick();
    a0 = 4'b0000;
    tick();
    check("midrst_offer_valid", 32'(valid0), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(valid0), 32'd0);
    check("midrst_id", 32'(id0), 32'd0);
    rst = 1'b0; ready0 = 1'b1; a1 = 4'b0100;
    tick();
    a1 = 4'b0000;
    tick(5);
    check("midrst_no_event_m0", 32'(valid0), 32'd0);
    check("postrst_no_event_m1", 32'(valid1), 32'd0);

    // Mode 1: 0,1,0 yields one event; 0,1,1,0 none; 0,1,0,1,0 two
    q1.push_back(2);
    a1 = 4'b0100;
    tick();
    a1 = 4'b0000;
    tick(4);
    check("m1_pulse_seen", 32'(q1.size()), 32'd0);
    a1 = 4'b0100;
    tick(2);
    a1 = 4'b0000;
    tick(5);
    check("m1_wide_ignored", 32'(valid1), 32'd0);
    q1.push_back(2); q1.push_back(2);
    a1 = 4'b0100;
    tick();
    a1 = 4'b0000;
    tick();
    a1 = 4'b0100;
    tick();
    a1 = 4'b0000;
    tick(6);

    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    check("final_q0_empty", 32'(q0.size()), 32'd0);
    check("final_q1_empty", 32'(q1.size()), 32'd0);
    check("final_m1_overflow", 32'(ovf1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
